// File: rtl/spi_keycode_pkg.sv
// spi_keycode_pkg: shared constants and FSM encoding for the SPI keycode slave
package spi_keycode_pkg;
    localparam logic [7:0] CMD_SET_KEY = 8'h01;
    localparam logic [7:0] CMD_CLR_KEY = 8'h02;
    localparam logic [7:0] SYNC_MARKER = 8'h5A;
    localparam int FRAME_BITS = 16;
    typedef enum logic [1:0] {IDLE, RECV, HOLD} spi_state_t;
endpackage

// File: rtl/spi_keycode_slave_sync.sv
// sync_edge: 2-FF synchronizer with registered rise/fall pulses and configurable reset level
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic MAX10_CLK1_50,
    input  logic Reset_h,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic r_s1, r_s2, r_s3, r_rise, r_fall;
    always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
        if (Reset_h) begin
            {r_s1, r_s2, r_s3, r_rise, r_fall} <= {RST_VAL, RST_VAL, RST_VAL, 1'b0, 1'b0};
        end else begin
            r_s1   <= i_d;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_rise <= r_s2 & ~r_s3;
            r_fall <= ~r_s2 & r_s3;
        end
    end
    assign o_level = r_s2;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
endmodule

// File: rtl/spi_keycode_slave.sv
// spi_keycode_slave: SPI mode-0 slave injecting Pac-Man keycodes and returning game status
module spi_keycode_slave
    import spi_keycode_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic       MAX10_CLK1_50,
    input  logic       Reset_h,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    input  logic [7:0] status_in,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [7:0] keycode,
    output logic       keycode_valid,
    output logic [7:0] err_count
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);

    logic w_sclk_lvl_unused, w_sclk_rise, w_sclk_fall;
    logic w_cs, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;
    spi_state_t r_state, w_state_n;
    logic w_start, w_shift, w_flag, w_done, w_short;
    logic w_good, w_set, w_clr, w_commit, w_bad, w_expire;
    logic [7:0] w_cmd;
    logic [4:0] r_cnt;
    logic [15:0] r_rx;
    logic [7:0] r_tx, r_status, r_key, r_err;
    logic r_long, r_armed, r_kv;
    logic [1:0] r_settle;
    logic [TW-1:0] r_tmo;

    sync_edge #(.RST_VAL(1'b0)) u_sclk (
        .MAX10_CLK1_50(MAX10_CLK1_50), .Reset_h(Reset_h), .i_d(spi_sclk),
        .o_level(w_sclk_lvl_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    sync_edge #(.RST_VAL(1'b1)) u_cs (
        .MAX10_CLK1_50(MAX10_CLK1_50), .Reset_h(Reset_h), .i_d(spi_cs_n),
        .o_level(w_cs), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );
    sync_edge #(.RST_VAL(1'b0)) u_mosi (
        .MAX10_CLK1_50(MAX10_CLK1_50), .Reset_h(Reset_h), .i_d(spi_mosi),
        .o_level(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
    );

    always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
        if (Reset_h) r_state <= IDLE;
        else         r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        w_start   = 1'b0;
        w_shift   = 1'b0;
        w_flag    = 1'b0;
        w_done    = 1'b0;
        w_short   = 1'b0;
        case (r_state)
            IDLE: if (w_cs_fall && r_armed) begin
                w_state_n = RECV;
                w_start   = 1'b1;
            end
            RECV: if (w_cs_rise) begin
                w_state_n = IDLE;
                w_short   = r_cnt != 5'd0;
            end else if (w_sclk_rise) begin
                w_shift   = 1'b1;
                w_state_n = (r_cnt == 5'(FRAME_BITS - 1)) ? HOLD : RECV;
            end
            HOLD: if (w_cs_rise) begin
                w_state_n = IDLE;
                w_done    = 1'b1;
            end else begin
                w_flag = w_sclk_rise;
            end
            default: w_state_n = IDLE;
        endcase
    end

    assign w_cmd    = r_rx[15:8];
    assign w_good   = w_done & ~r_long;
    assign w_set    = w_good && w_cmd == CMD_SET_KEY;
    assign w_clr    = w_good && w_cmd == CMD_CLR_KEY;
    assign w_commit = w_set | w_clr;
    assign w_bad    = w_short | (w_done & r_long) | (w_good & ~w_commit);
    // a commit landing on the expiry cycle wins and reloads the timer
    assign w_expire = (r_tmo == TW'(1)) & ~w_commit;

    always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
        if (Reset_h) begin
            r_settle <= 2'd0;
            r_armed  <= 1'b0;
            r_cnt    <= 5'd0;
            r_rx     <= 16'd0;
            r_long   <= 1'b0;
            r_status <= 8'd0;
            r_tx     <= 8'd0;
            r_tmo    <= TMO_LOAD;
            r_key    <= 8'd0;
            r_kv     <= 1'b0;
            r_err    <= 8'd0;
        end else begin
            // a CS_n already low when reset lifts must be seen high before any frame is accepted
            r_settle <= (&r_settle) ? r_settle : r_settle + 2'd1;
            r_armed  <= r_armed | (&r_settle & w_cs);
            r_cnt    <= w_start ? 5'd0 : w_shift ? r_cnt + 5'd1 : r_cnt;
            r_rx     <= w_shift ? {r_rx[14:0], w_mosi} : r_rx;
            r_long   <= w_start ? 1'b0 : (r_long | w_flag);
            r_status <= w_start ? status_in : r_status;
            r_tx     <= w_start ? SYNC_MARKER :
                        (w_sclk_fall && r_state != IDLE) ?
                            ((r_cnt == 5'(FRAME_BITS / 2)) ? r_status : {r_tx[6:0], 1'b0}) : r_tx;
            r_tmo    <= w_commit ? TMO_LOAD : (r_tmo != '0) ? r_tmo - TW'(1) : r_tmo;
            r_key    <= w_set ? r_rx[7:0] : (w_clr | w_expire) ? 8'd0 : r_key;
            r_kv     <= w_commit | (w_expire & (r_key != 8'd0));
            r_err    <= (w_bad && r_err != 8'hFF) ? r_err + 8'd1 : r_err;
        end
    end

    assign spi_miso      = r_tx[7];
    assign spi_miso_oe   = ~w_cs;
    assign keycode       = r_key;
    assign keycode_valid = r_kv;
    assign err_count     = r_err;
endmodule

// File: tb/tb_spi_keycode_slave.sv
// tb_spi_keycode_slave: table-driven and randomized self-checking bench for spi_keycode_slave
module tb_spi_keycode_slave;
    localparam int TMO = 1000;

    logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic [7:0] status = 8'h00;
    logic miso, oe, kv;
    logic [7:0] key, err;

    int checks = 0, errors = 0, pulses = 0, cyc = 0;
    logic [7:0] exp_key = 8'h00, exp_err = 8'h00;

    spi_keycode_slave #(.TIMEOUT_CYCLES(TMO)) dut (
        .MAX10_CLK1_50(clk), .Reset_h(rst), .spi_sclk(sclk), .spi_cs_n(cs_n),
        .spi_mosi(mosi), .status_in(status), .spi_miso(miso), .spi_miso_oe(oe),
        .keycode(key), .keycode_valid(kv), .err_count(err)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (kv) pulses <= pulses + 1;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bits(input int nb, input logic [31:0] word, input int hp, input logic [7:0] st,
                        output logic [31:0] rx);
        rx = 32'd0;
        for (int i = 0; i < nb; i++) begin
            mosi = word[31-i];
            if (i == 1) status = ~st;
            step(hp);
            sclk = 1'b1;
            rx = {rx[30:0], miso};
            step(hp);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_open(input int nb, input logic [31:0] word, input int hp, input logic [7:0] st,
                              output logic [31:0] rx);
        status = st;
        cs_n = 1'b0;
        step(hp);
        bits(nb, word, hp, st, rx);
        step(hp);
    endtask

    task automatic frame_close();
        cs_n = 1'b1;
        step(8);
    endtask

    task automatic send_frame(input int nb, input logic [7:0] cmd, input logic [7:0] data, input int hp,
                              input logic [7:0] st, output logic [31:0] rx);
        frame_open(nb, {cmd, data, 16'($urandom)}, hp, st, rx);
        frame_close();
    endtask

    task automatic model(input int nb, input logic [7:0] cmd, input logic [7:0] data, output int pul);
        pul = 0;
        if (nb == 16 && (cmd == 8'h01 || cmd == 8'h02)) begin
            exp_key = (cmd == 8'h01) ? data : 8'h00;
            pul = 1;
        end else if (nb > 0 && exp_err != 8'hFF) begin
            exp_err = exp_err + 8'd1;
        end
    endtask

    typedef struct {
        int nb;
        logic [7:0] cmd, data, st;
        int hp;
        logic [7:0] key, err;
        int pul;
    } vec_t;

    vec_t tbl[8];
    int nbs[9] = '{0, 3, 15, 16, 16, 16, 16, 17, 20};

    initial begin
        logic [31:0] rx, sh;
        int p0, pul, nb, hp, inv, e0;
        logic [7:0] cmd, data, st;
        tbl[0] = '{16, 8'h01, 8'h1A, 8'hB4, 25, 8'h1A, 8'd0, 1};
        tbl[1] = '{16, 8'h01, 8'h07, 8'h64, 5, 8'h07, 8'd0, 1};
        tbl[2] = '{16, 8'h02, 8'hFF, 8'h28, 5, 8'h00, 8'd0, 1};
        tbl[3] = '{16, 8'h01, 8'h3C, 8'hC0, 5, 8'h3C, 8'd0, 1};
        tbl[4] = '{12, 8'h01, 8'h55, 8'h00, 5, 8'h3C, 8'd1, 0};
        tbl[5] = '{17, 8'h01, 8'h55, 8'h00, 5, 8'h3C, 8'd2, 0};
        tbl[6] = '{16, 8'h33, 8'h44, 8'h00, 5, 8'h3C, 8'd3, 0};
        tbl[7] = '{0, 8'h01, 8'h11, 8'h00, 5, 8'h3C, 8'd3, 0};

        step(3);
        check("reset keycode", 32'(key), 32'h00);
        check("reset valid", 32'(kv), 32'h0);
        check("reset err", 32'(err), 32'h00);
        check("reset miso", 32'(miso), 32'h0);
        check("reset oe", 32'(oe), 32'h0);
        rst = 1'b0;
        step(10);
        check("idle oe", 32'(oe), 32'h0);

        p0 = pulses;
        frame_open(16, {8'h01, 8'h2B, 16'h0000}, 5, 8'h94, rx);
        check("oe in frame", 32'(oe), 32'h1);
        cs_n = 1'b1;
        step(3);
        check("commit not early", 32'(kv), 32'h0);
        step(1);
        check("commit pulse at 4", 32'(kv), 32'h1);
        check("commit key at 4", 32'(key), 32'h2B);
        step(1);
        check("pulse one cycle", 32'(kv), 32'h0);
        step(6);
        check("timing pulse count", 32'(pulses - p0), 32'd1);
        check("timing miso", 32'(rx[15:0]), 32'h5A94);

        for (int i = 0; i < 8; i++) begin
            p0 = pulses;
            send_frame(tbl[i].nb, tbl[i].cmd, tbl[i].data, tbl[i].hp, tbl[i].st, rx);
            check($sformatf("tbl%0d key", i), 32'(key), 32'(tbl[i].key));
            check($sformatf("tbl%0d err", i), 32'(err), 32'(tbl[i].err));
            check($sformatf("tbl%0d pulses", i), 32'(pulses - p0), 32'(tbl[i].pul));
            if (tbl[i].nb >= 16) begin
                sh = rx >> (tbl[i].nb - 16);
                check($sformatf("tbl%0d miso", i), 32'(sh[15:0]), 32'({8'h5A, tbl[i].st}));
            end
        end

        exp_key = 8'h3C;
        exp_err = 8'd3;
        inv = 3;
        for (int i = 0; i < 40; i++) begin
            nb = nbs[$urandom_range(0, 8)];
            case ($urandom_range(0, 3))
                0: cmd = 8'h01;
                1: cmd = 8'h02;
                default: cmd = 8'($urandom);
            endcase
            if (inv >= 2) begin
                nb = 16;
                cmd = ($urandom_range(0, 1) == 1) ? 8'h01 : 8'h02;
            end
            data = 8'($urandom);
            st = 8'($urandom) & 8'hFC;
            hp = $urandom_range(5, 6);
            inv = (nb == 16 && (cmd == 8'h01 || cmd == 8'h02)) ? 0 : inv + 1;
            model(nb, cmd, data, pul);
            p0 = pulses;
            send_frame(nb, cmd, data, hp, st, rx);
            check($sformatf("rnd%0d key", i), 32'(key), 32'(exp_key));
            check($sformatf("rnd%0d err", i), 32'(err), 32'(exp_err));
            check($sformatf("rnd%0d pulses", i), 32'(pulses - p0), 32'(pul));
            if (nb >= 16) begin
                sh = rx >> (nb - 16);
                check($sformatf("rnd%0d miso", i), 32'(sh[15:0]), 32'({8'h5A, st}));
            end
        end

        send_frame(16, 8'h01, 8'h16, 5, 8'h00, rx);
        p0 = pulses;
        step(TMO - 5);
        check("timeout not early", 32'(key), 32'h16);
        check("timeout no pulse yet", 32'(pulses - p0), 32'd0);
        step(1);
        check("timeout clears", 32'(key), 32'h00);
        check("timeout pulse", 32'(pulses - p0), 32'd1);
        step(5000);
        check("timeout single pulse", 32'(pulses - p0), 32'd1);

        send_frame(16, 8'h01, 8'h21, 5, 8'h00, rx);
        e0 = cyc - 4;
        p0 = pulses;
        frame_open(16, {8'h01, 8'h4D, 16'h0000}, 5, 8'h00, rx);
        while (cyc < e0 + TMO - 4) step(1);
        cs_n = 1'b1;
        step(4);
        check("race pulse", 32'(kv), 32'h1);
        check("race commit wins", 32'(key), 32'h4D);
        step(TMO - 1);
        check("race timer reloaded", 32'(key), 32'h4D);
        check("race pulses", 32'(pulses - p0), 32'd1);
        step(1);
        check("race later expiry", 32'(key), 32'h00);
        step(4);
        exp_key = 8'h00;

        for (int i = 0; i < 260; i++) begin
            model(1, 8'h01, 8'h00, pul);
            send_frame(1, 8'h01, 8'h00, 3, 8'h00, rx);
        end
        check("err saturates", 32'(err), 32'hFF);
        check("err model", 32'(err), 32'(exp_err));

        send_frame(16, 8'h01, 8'h5E, 5, 8'h00, rx);
        check("pre-reset key", 32'(key), 32'h5E);
        cs_n = 1'b0;
        step(5);
        bits(9, 32'h0133_0000, 5, 8'h00, rx);
        rst = 1'b1;
        step(2);
        check("midreset key", 32'(key), 32'h00);
        check("midreset valid", 32'(kv), 32'h0);
        check("midreset err", 32'(err), 32'h00);
        check("midreset miso", 32'(miso), 32'h0);
        check("midreset oe", 32'(oe), 32'h0);
        rst = 1'b0;
        p0 = pulses;
        step(20);
        bits(16, 32'h0177_0000, 5, 8'h00, rx);
        step(5);
        check("cs low after reset no err", 32'(err), 32'h00);
        frame_close();
        check("cs low after reset no commit", 32'(key), 32'h00);
        check("cs low after reset err", 32'(err), 32'h00);
        check("cs low after reset pulses", 32'(pulses - p0), 32'd0);
        send_frame(16, 8'h01, 8'h39, 5, 8'hA8, rx);
        check("post-reset commit", 32'(key), 32'h39);
        check("post-reset pulses", 32'(pulses - p0), 32'd1);
        check("post-reset miso", 32'(rx[15:0]), 32'h5AA8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
